// File: rtl/_rr_arb_mux_pkg.sv
// rtl/_rr_arb_mux_pkg.sv - shared datapath constants used by the arbitrated mux
package constants;
  localparam int WORD_LENGTH = 32;
endpackage

// File: rtl/_rr_arb_mux_arbiter.sv
// rtl/_rr_arb_mux_arbiter.sv - combinational round-robin arbiter, one-hot grant
module _rr_arbiter #(
  parameter int CH = 4,
  localparam int SEL_W = $clog2(CH)
) (
  input  logic [CH-1:0]    req,
  input  logic [SEL_W-1:0] ptr,
  output logic [CH-1:0]    gnt
);
  logic [2*CH-1:0] req_dbl;
  logic [2*CH-1:0] req_rot;
  logic            found;
  int              idx;

  // Rotating the doubled vector puts req[ptr] at bit 0, so a plain
  // lowest-bit-first search yields the round-robin winner.
  always_comb begin
    req_dbl = {req, req};
    req_rot = req_dbl >> ptr;
    gnt     = '0;
    found   = 1'b0;
    idx     = 0;
    for (int i = 0; i < CH; i++) begin
      if (!found && req_rot[i]) begin
        found    = 1'b1;
        idx      = (int'(ptr) + i) % CH;
        gnt[idx] = 1'b1;
      end
    end
  end
endmodule

// File: rtl/_rr_arb_mux.sv
// rtl/_rr_arb_mux.sv - round-robin arbitrated mux with optional packet lock
// and a registered single-entry output slice.
module _rr_arb_mux
  import constants::*;
#(
  parameter int n    = WORD_LENGTH,
  parameter int CH   = 4,
  parameter bit LOCK = 1'b0,
  localparam int SEL_W = $clog2(CH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CH-1:0]    in_valid,
  output logic [CH-1:0]    in_ready,
  input  logic [n-1:0]     in_data [CH-1:0],
  input  logic [CH-1:0]    in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [n-1:0]     out_data,
  output logic             out_last,
  output logic [SEL_W-1:0] out_sel
);
  typedef enum logic {LK_IDLE, LK_LOCKED} lock_state_e;

  lock_state_e      lock_q, lock_d;
  logic [SEL_W-1:0] owner_q, owner_d;
  logic [SEL_W-1:0] rr_ptr_q, rr_ptr_d;
  logic             out_valid_q, out_valid_d;
  logic [n-1:0]     out_data_q, out_data_d;
  logic             out_last_q, out_last_d;
  logic [SEL_W-1:0] out_sel_q, out_sel_d;

  logic [CH-1:0]    req;
  logic [CH-1:0]    gnt;
  logic [SEL_W-1:0] g;
  logic             load_ok;
  logic             accept;

  // While locked only the owner may compete; if it idles nobody is granted.
  always_comb begin
    req = in_valid;
    if (LOCK && lock_q == LK_LOCKED) begin
      req = in_valid & (CH'(1) << owner_q);
    end
  end

  _rr_arbiter #(.CH(CH)) u_arbiter (
    .req (req),
    .ptr (rr_ptr_q),
    .gnt (gnt)
  );

  always_comb begin
    load_ok  = !out_valid_q || out_ready;
    in_ready = (rst || !load_ok) ? '0 : gnt;
    accept   = |(in_valid & in_ready);
    g        = '0;
    for (int i = 0; i < CH; i++) begin
      if (gnt[i]) g = SEL_W'(i);
    end

    lock_d      = lock_q;
    owner_d     = owner_q;
    rr_ptr_d    = rr_ptr_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    out_sel_d   = out_sel_q;

    if (accept) begin
      out_valid_d = 1'b1;
      out_data_d  = in_data[g];
      out_last_d  = in_last[g];
      out_sel_d   = g;
      // A non-last beat under LOCK pins both the owner and the pointer.
      if (LOCK && !in_last[g]) begin
        lock_d  = LK_LOCKED;
        owner_d = g;
      end else begin
        lock_d   = LK_IDLE;
        rr_ptr_d = (g == SEL_W'(CH - 1)) ? '0 : g + SEL_W'(1);
      end
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lock_q      <= LK_IDLE;
      owner_q     <= '0;
      rr_ptr_q    <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      out_sel_q   <= '0;
    end else begin
      lock_q      <= lock_d;
      owner_q     <= owner_d;
      rr_ptr_q    <= rr_ptr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      out_sel_q   <= out_sel_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign out_sel   = out_sel_q;
endmodule

// File: tb/tb__rr_arb_mux.sv
// tb/tb__rr_arb_mux.sv - bench for _rr_arb_mux, LOCK=0 and LOCK=1 instances
module tb__rr_arb_mux;
  localparam int CH = 4;
  localparam int W  = 32;

  logic          clk;
  logic          rst;
  logic [CH-1:0] in_valid;
  logic [W-1:0]  in_data [CH-1:0];
  logic [CH-1:0] in_last;
  logic          out_ready;

  logic [CH-1:0] in_ready_w  [2];
  logic          out_valid_w [2];
  logic [W-1:0]  out_data_w  [2];
  logic          out_last_w  [2];
  logic [1:0]    out_sel_w   [2];

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    _rr_arb_mux #(.n(W), .CH(CH), .LOCK(gi == 1)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready_w[gi]),
      .in_data   (in_data),
      .in_last   (in_last),
      .out_valid (out_valid_w[gi]),
      .out_ready (out_ready),
      .out_data  (out_data_w[gi]),
      .out_last  (out_last_w[gi]),
      .out_sel   (out_sel_w[gi])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    else n_pass++;
  endtask

  // Reference model state, index 0 = LOCK off, 1 = LOCK on
  int          m_ptr    [2];
  int          m_owner  [2];
  bit          m_locked [2];
  bit          m_ov     [2];
  bit          m_ol     [2];
  logic [W-1:0] m_od    [2];
  int          m_os     [2];
  bit          started = 1'b0;

  function automatic int exp_grant(input int m);
    if (m_locked[m]) return in_valid[m_owner[m]] ? m_owner[m] : -1;
    for (int i = 0; i < CH; i++) begin
      if (in_valid[(m_ptr[m] + i) % CH]) return (m_ptr[m] + i) % CH;
    end
    return -1;
  endfunction

  function automatic logic [CH-1:0] exp_ready(input int m);
    int g;
    g = exp_grant(m);
    if (rst || !(!m_ov[m] || out_ready) || g < 0) return '0;
    return CH'(1) << g;
  endfunction

  task automatic model_step();
    int  g;
    bit  acc;
    for (int m = 0; m < 2; m++) begin
      g   = exp_grant(m);
      acc = !rst && g >= 0 && (!m_ov[m] || out_ready);
      if (rst) begin
        m_ov[m] = 0; m_od[m] = '0; m_ol[m] = 0; m_os[m] = 0;
        m_ptr[m] = 0; m_locked[m] = 0; m_owner[m] = 0;
      end else if (acc) begin
        m_ov[m] = 1; m_od[m] = in_data[g]; m_ol[m] = in_last[g]; m_os[m] = g;
        if (m == 1 && !in_last[g]) begin
          m_locked[m] = 1; m_owner[m] = g;
        end else begin
          m_locked[m] = 0; m_ptr[m] = (g + 1) % CH;
        end
      end else if (out_ready) begin
        m_ov[m] = 0;
      end
    end
  endtask

  // Caller sets inputs at the negedge; this checks ready, clocks, then checks registers.
  task automatic cycle();
    #1;
    if (started) begin
      for (int m = 0; m < 2; m++)
        check($sformatf("m%0d in_ready", m), 64'(in_ready_w[m]), 64'(exp_ready(m)));
    end
    @(posedge clk);
    model_step();
    started = 1'b1;
    @(negedge clk);
    for (int m = 0; m < 2; m++) begin
      check($sformatf("m%0d out_valid", m), 64'(out_valid_w[m]), 64'(m_ov[m]));
      if (m_ov[m] || rst) begin
        check($sformatf("m%0d out_data", m), 64'(out_data_w[m]), 64'(m_od[m]));
        check($sformatf("m%0d out_last", m), 64'(out_last_w[m]), 64'(m_ol[m]));
        check($sformatf("m%0d out_sel", m),  64'(out_sel_w[m]),  64'(m_os[m]));
      end
    end
  endtask

  task automatic rand_data();
    for (int i = 0; i < CH; i++) in_data[i] = $urandom;
  endtask

  int exp_lock_seq [5] = '{1, 1, 1, 3, 0};

  initial begin
    rst = 1'b1; in_valid = '1; in_last = '1; out_ready = 1'b1;
    rand_data();

    // Reset with every channel requesting
    repeat (2) begin
      cycle();
      check("rst in_ready0", 64'(in_ready_w[0]), 64'(0));
      check("rst out_sel0",  64'(out_sel_w[0]),  64'(0));
    end

    // Round-robin rotation on LOCK=0
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      rand_data();
      cycle();
      check("rr_seq", 64'(out_sel_w[0]), 64'(i % 4));
    end

    // Backpressure: beat A5 from ch2 held while out_ready is low
    in_valid = 4'b0100; in_data[2] = 32'hA5; out_ready = 1'b1;
    cycle();
    in_valid = '1; out_ready = 1'b0;
    repeat (3) begin
      rand_data();
      #1;
      check("bp in_ready", 64'(in_ready_w[0]), 64'(0));
      cycle();
      check("bp out_data", 64'(out_data_w[0]), 64'(32'hA5));
      check("bp out_sel",  64'(out_sel_w[0]),  64'(2));
    end
    out_ready = 1'b1;
    cycle();

    // Lock: align pointer to ch1, then a 3-beat ch1 packet with ch0/ch3 competing
    rst = 1'b1; cycle(); rst = 1'b0;
    in_valid = 4'b0001; in_last = '1; cycle();
    for (int i = 0; i < 5; i++) begin
      in_valid = 4'b1011;
      in_last  = (i == 2 || i > 2) ? 4'b1111 : 4'b1101;
      rand_data();
      cycle();
      check("lock_seq", 64'(out_sel_w[1]), 64'(exp_lock_seq[i]));
    end

    // Lock gap: ch1 drops valid mid-packet while ch0/ch3 keep requesting
    rst = 1'b1; cycle(); rst = 1'b0;
    in_valid = 4'b0001; in_last = '1; cycle();
    in_valid = 4'b0010; in_last = 4'b1101; cycle();
    in_valid = 4'b1001; cycle(); cycle();
    check("gap out_valid", 64'(out_valid_w[1]), 64'(0));
    in_valid = 4'b1011; cycle();
    check("gap owner", 64'(out_sel_w[1]), 64'(1));
    in_last = '1; cycle();

    // Reset mid-packet with ch2 locked
    in_valid = 4'b0100; in_last = 4'b1011; cycle(); cycle();
    rst = 1'b1; cycle();
    check("midrst out_valid", 64'(out_valid_w[1]), 64'(0));
    rst = 1'b0; in_valid = '1; in_last = 4'b1011; cycle();
    check("midrst first", 64'(out_sel_w[1]), 64'(0));

    // Randomized traffic
    for (int i = 0; i < 2000; i++) begin
      rst       = ($urandom_range(0, 63) == 0);
      in_valid  = CH'($urandom);
      in_last   = CH'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      rand_data();
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
